// File: rtl/time_fmt_pkg.sv
// Shared BCD time-display definitions: digit limits, range limits, FSM encoding, saturation pattern.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package time_fmt_pkg;

    localparam logic [3:0]  SEC_TENS_MAX   = 4'd5;
    localparam logic [3:0]  DIG_MAX        = 4'd9;

    localparam logic [19:0] MAX_SEC_MMSS   = 20'd5999;    // 99:59
    localparam logic [19:0] MAX_SEC_HHMMSS = 20'd359999;  // 99:59:59

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Largest whole-second value the display can show for a given field count.
    function automatic logic [19:0] max_sec(input int fields);
        return (fields == 3) ? MAX_SEC_HHMMSS : MAX_SEC_MMSS;
    endfunction

    // Tens-digit wrap limit of a field: the top field is allowed to run to 9.
    function automatic logic [3:0] tens_max(input int field, input int fields);
        return (field == fields - 1) ? DIG_MAX : SEC_TENS_MAX;
    endfunction

    // Display shown on overflow: every ones digit 9, tens digits at their limit.
    function automatic logic [23:0] sat_pattern(input int fields);
        logic [23:0] pat;
        pat = '0;
        for (int f = 0; f < fields; f++) begin
            pat[8*f +: 4]     = DIG_MAX;
            pat[8*f + 4 +: 4] = tens_max(f, fields);
        end
        return pat;
    endfunction

endpackage

// File: rtl/bcd_time_inc.sv
// Adds one second to a packed BCD time value (ss, mm:ss or hh:mm:ss), ripple carry across fields.
// Latency: purely combinational.
// Backpressure: none.
module bcd_time_inc
    import time_fmt_pkg::*;
#(
    parameter int FIELDS = 2
) (
    input  logic [8*FIELDS-1:0] bcd_cur,
    output logic [8*FIELDS-1:0] bcd_nxt
);

    logic carry;

    // Walk fields from seconds upward; each digit wraps at its limit and passes the carry on.
    always_comb begin
        bcd_nxt = bcd_cur;
        carry   = 1'b1;
        for (int f = 0; f < FIELDS; f++) begin
            if (carry) begin
                if (bcd_cur[8*f +: 4] == DIG_MAX) begin
                    bcd_nxt[8*f +: 4] = 4'd0;
                    if (bcd_cur[8*f + 4 +: 4] == tens_max(f, FIELDS)) begin
                        bcd_nxt[8*f + 4 +: 4] = 4'd0;
                    end else begin
                        bcd_nxt[8*f + 4 +: 4] = bcd_cur[8*f + 4 +: 4] + 4'd1;
                        carry                 = 1'b0;
                    end
                end else begin
                    bcd_nxt[8*f +: 4] = bcd_cur[8*f +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dur_bcd_time_conv.sv
// Converts a tick-count duration into a packed BCD mm:ss / hh:mm:ss display value by counting seconds.
// Latency: target N publishes N+2 edges after LOAD entry; overflow saturates one edge after LOAD entry.
// Backpressure: none; input is quasi-static, any change of whole seconds restarts the conversion.
module dur_bcd_time_conv
    import time_fmt_pkg::*;
#(
    parameter int IN_W       = 12,
    parameter int FRAC_SHIFT = 2,
    parameter int FIELDS     = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [IN_W-1:0]     dur_in,
    output logic [8*FIELDS-1:0] time_bcd,
    output logic                time_valid,
    output logic                busy,
    output logic                overflow
);

    localparam int          CNT_W    = IN_W - FRAC_SHIFT;
    localparam int          BCD_W    = 8 * FIELDS;
    localparam logic [23:0] SAT_FULL = sat_pattern(FIELDS);
    localparam logic [31:0] MAX_EXT  = 32'(max_sec(FIELDS));

    conv_state_t      state;
    conv_state_t      state_nxt;
    logic [CNT_W-1:0] tgt_in;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] count;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_inc;
    logic             tgt_over;
    logic             tgt_changed;
    logic             count_hit;

    // Sub-second ticks are dropped; only a change in whole seconds matters.
    assign tgt_in      = dur_in[IN_W-1:FRAC_SHIFT];
    assign tgt_over    = 32'(tgt_in) > MAX_EXT;
    assign tgt_changed = (tgt_in != target);
    assign count_hit   = (count == target);

    generate
        if (FRAC_SHIFT > 0) begin : g_frac
            logic unused_frac;
            assign unused_frac = ^dur_in[FRAC_SHIFT-1:0];
        end
    endgenerate

    bcd_time_inc #(
        .FIELDS  (FIELDS)
    ) u_inc (
        .bcd_cur (acc),
        .bcd_nxt (acc_inc)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a changed target always wins over finishing the current count.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  state_nxt = tgt_over ? ST_DONE : ST_COUNT;
            ST_COUNT: begin
                if (tgt_changed) begin
                    state_nxt = ST_LOAD;
                end else if (count_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = tgt_changed ? ST_LOAD : ST_DONE;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // Busy follows the state register so it flips on the same edge as the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy <= 1'b1;
        end else begin
            busy <= (state_nxt != ST_DONE);
        end
    end

    // Counting datapath; time_bcd only updates on publish so the display never flickers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            target     <= '0;
            count      <= '0;
            acc        <= '0;
            time_bcd   <= '0;
            time_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    target     <= tgt_in;
                    count      <= '0;
                    acc        <= '0;
                    time_valid <= 1'b0;
                    if (tgt_over) begin
                        overflow   <= 1'b1;
                        time_bcd   <= SAT_FULL[BCD_W-1:0];
                        time_valid <= 1'b1;
                    end else begin
                        overflow   <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (tgt_changed) begin
                        time_valid <= 1'b0;
                    end else if (count_hit) begin
                        time_bcd   <= acc;
                        time_valid <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                        acc   <= acc_inc;
                    end
                end
                ST_DONE: begin
                    if (tgt_changed) begin
                        time_valid <= 1'b0;
                    end
                end
                default: begin
                    time_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dur_bcd_time_conv.sv
// Bench for dur_bcd_time_conv: three configurations (mm:ss 12-bit, mm:ss 16-bit, hh:mm:ss 22-bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_dur_bcd_time_conv;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [11:0] dur0 = '0;
    logic [15:0] dur1 = '0;
    logic [21:0] dur2 = '0;
    logic [15:0] bcd0, bcd1;
    logic [23:0] bcd2;
    logic        vld0, vld1, vld2;
    logic        busy0, busy1, busy2;
    logic        ovf0, ovf1, ovf2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    dur_bcd_time_conv #(.IN_W(12), .FRAC_SHIFT(2), .FIELDS(2)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dur_in(dur0),
        .time_bcd(bcd0), .time_valid(vld0), .busy(busy0), .overflow(ovf0));

    dur_bcd_time_conv #(.IN_W(16), .FRAC_SHIFT(2), .FIELDS(2)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dur_in(dur1),
        .time_bcd(bcd1), .time_valid(vld1), .busy(busy1), .overflow(ovf1));

    dur_bcd_time_conv #(.IN_W(22), .FRAC_SHIFT(2), .FIELDS(3)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dur_in(dur2),
        .time_bcd(bcd2), .time_valid(vld2), .busy(busy2), .overflow(ovf2));

    typedef struct {
        int          sel;
        int          dur;
        logic [23:0] exp_bcd;
        logic        exp_ovf;
        int          exp_lat;   // edges from stimulus to time_valid rising
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[11];

    function automatic logic [23:0] get_bcd(input int sel);
        case (sel)
            0:       return {8'h00, bcd0};
            1:       return {8'h00, bcd1};
            default: return bcd2;
        endcase
    endfunction

    function automatic logic get_vld(input int sel);
        case (sel)
            0:       return vld0;
            1:       return vld1;
            default: return vld2;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    function automatic vec_t mk(input int sel, input int dur, input logic [23:0] b,
                                input logic o, input int lat);
        vec_t v;
        v.sel = sel; v.dur = dur; v.exp_bcd = b; v.exp_ovf = o; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_dur(input int sel, input int d);
        case (sel)
            0:       dur0 = 12'(d);
            1:       dur1 = 16'(d);
            default: dur2 = 22'(d);
        endcase
    endtask

    // Wait (bounded) for the next publish on a DUT and score it against the queue head.
    task automatic wait_pub(input int sel, input string nm);
        int   n;
        logic prev_busy;
        vec_t e;
        n = 0;
        prev_busy = 1'b1;
        do begin
            prev_busy = get_busy(sel);
            @(posedge sys_clk); #1;
            n++;
        end while (!get_vld(sel) && n < 20000);
        e = sb_q.pop_front();
        chk({nm, "_valid"}, 32'(get_vld(sel)), 32'd1);
        chk({nm, "_latency"}, n, e.exp_lat);
        chk({nm, "_bcd"}, 32'(get_bcd(sel)), 32'(e.exp_bcd));
        chk({nm, "_overflow"}, 32'(get_ovf(sel)), 32'(e.exp_ovf));
        chk({nm, "_busy_after"}, 32'(get_busy(sel)), 32'd0);
        if (n > 1) chk({nm, "_busy_before"}, 32'(prev_busy), 32'd1);
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        @(negedge sys_clk);
        set_dur(v.sel, v.dur);
        sb_q.push_back(v);
        wait_pub(v.sel, nm);
    endtask

    initial begin
        tbl[0]  = mk(0,     240, 24'h000100, 1'b0,   63);   // 60 s
        tbl[1]  = mk(0,    2400, 24'h001000, 1'b0,  603);   // 600 s
        tbl[2]  = mk(0,       0, 24'h000000, 1'b0,    3);   // zero target
        tbl[3]  = mk(0,       4, 24'h000001, 1'b0,    4);
        tbl[4]  = mk(0,    4095, 24'h001703, 1'b0, 1026);   // 1023 s, full input range
        tbl[5]  = mk(2,   14400, 24'h010000, 1'b0, 3603);   // 3600 s
        tbl[6]  = mk(2,   14900, 24'h010205, 1'b0, 3728);   // 3725 s
        tbl[7]  = mk(1,   24000, 24'h009959, 1'b1,    2);   // 6000 s overflow
        tbl[8]  = mk(1,       4, 24'h000001, 1'b0,    4);
        tbl[9]  = mk(1,   23996, 24'h009959, 1'b0, 6002);   // exactly 5999 s
        tbl[10] = mk(2, 1440000, 24'h995959, 1'b1,    2);   // 360000 s overflow

        // Reset state with the clock running.
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_bcd", 32'(bcd0), 32'd0);
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd1);
        chk("rst_overflow", 32'(ovf0), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_hold_busy", 32'(busy0), 32'd1);
        chk("rst_hold_valid", 32'(vld0), 32'd0);

        // Release with 63 s: valid on edge 65 after release.
        @(negedge sys_clk);
        dur0 = 12'd252;
        sys_rst_n = 1'b1;
        sb_q.push_back(mk(0, 252, 24'h000103, 1'b0, 65));
        wait_pub(0, "reset_63s");
        chk("init1_valid", 32'(vld1), 32'd1);
        chk("init2_bcd", 32'(bcd2), 32'd0);

        for (int i = 0; i < 11; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Mid-conversion change: old value held, no intermediate 100 s publish.
        @(negedge sys_clk);
        dur0 = 12'd400;
        for (int i = 0; i < 40; i++) begin
            @(posedge sys_clk); #1;
            chk("mid_valid_low", 32'(vld0), 32'd0);
            chk("mid_bcd_held", 32'(bcd0), 32'h1703);
        end
        @(negedge sys_clk);
        dur0 = 12'd8;
        sb_q.push_back(mk(0, 8, 24'h000002, 1'b0, 5));
        wait_pub(0, "mid_change");

        // Fractional-only change is ignored.
        apply_vec(mk(0, 252, 24'h000103, 1'b0, 66), "pre_lowbit");
        @(negedge sys_clk);
        dur0 = 12'd253;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            chk("lowbit_valid", 32'(vld0), 32'd1);
            chk("lowbit_busy", 32'(busy0), 32'd0);
            chk("lowbit_bcd", 32'(bcd0), 32'h0103);
        end

        // Asynchronous reset between edges in the middle of a count.
        @(negedge sys_clk);
        dur0 = 12'd400;
        repeat (20) @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_bcd", 32'(bcd0), 32'd0);
        chk("arst_valid", 32'(vld0), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd1);
        chk("arst_overflow", 32'(ovf0), 32'd0);
        dur0 = 12'd0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        sb_q.push_back(mk(0, 0, 24'h000000, 1'b0, 2));
        wait_pub(0, "arst_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
